imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 28 ++
 rtl/imem_array.sv | 38 +++
 rtl/imem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
// Contents:
//   imem_state_t   - responder FSM states (idle / wait-state countdown / response)
//   ERR_WORD       - word returned with resp_err for bad fetch addresses
//   DEFAULT_DEPTH  - default memory size in 32-bit words
//   DEFAULT_WAIT   - default number of wait states
//   addr_ok()      - true when a byte address is word aligned and inside memory
package imem_pkg;

  // The ST_ prefix keeps the state names apart from the WAIT parameter
  // of the responder.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } imem_state_t;

  localparam logic [31:0] ERR_WORD      = 32'h0000_0000;
  localparam int          DEFAULT_DEPTH = 1024;
  localparam int          DEFAULT_WAIT  = 2;

  // An address is usable when its two low bits are zero and nothing is set
  // above the word-index field.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned idx_bits);
    return (addr[1:0] == 2'b00) && ((addr >> (idx_bits + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction storage: one synchronous read port and one
// write port, no reset, so contents survive a responder reset.
// Ports:
//   clk      - clock
//   rd_en    - capture mem[rd_idx] into rd_data at the rising edge
//   rd_idx   - read word index
//   rd_data  - registered read word; holds its value while rd_en is low
//   wr_en    - write wr_data to mem[wr_idx] at the rising edge
//   wr_idx   - write word index
//   wr_data  - write word
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [31:0]              rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [31:0]              wr_data
);

  logic [31:0] mem [DEPTH];

  // Both ports sample the array before the edge, so a read and a write of
  // the same word in one cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one fetch request at a time, waits
// WAIT cycles, then presents the instruction word until the fetch stage
// takes it. A loader port may write the memory in any state.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   req_valid  - fetch request present
//   req_ready  - a request can be accepted this cycle
//   req_addr   - byte address (fetch PC)
//   resp_valid - response word present
//   resp_ready - fetch stage takes the response this cycle
//   resp_data  - instruction word (ERR_WORD on error)
//   resp_err   - request was misaligned or out of range
//   ld_en      - loader write strobe
//   ld_addr    - loader byte address
//   ld_data    - loader write word
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WAIT  = DEFAULT_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int IDX_BITS = $clog2(DEPTH);

  imem_state_t         state;
  logic [3:0]          wait_cnt;
  logic [IDX_BITS-1:0] addr_idx;
  logic                addr_err;

  logic [IDX_BITS-1:0] req_idx;
  logic [IDX_BITS-1:0] ld_idx;
  logic [IDX_BITS-1:0] rd_idx;
  logic                req_ok;
  logic                ld_ok;
  logic                accept;
  logic                rd_en;
  logic                wr_en;
  logic [31:0]         rd_data;

  assign req_idx = req_addr[IDX_BITS+1:2];
  assign ld_idx  = ld_addr[IDX_BITS+1:2];
  assign req_ok  = addr_ok(req_addr, IDX_BITS);
  assign ld_ok   = addr_ok(ld_addr, IDX_BITS);
  assign accept  = (state == ST_IDLE) && req_valid;

  // The read is issued in the last wait cycle (counter at 1) so the word is
  // registered on the same edge that enters RESP. With no wait states the
  // read must come straight from the incoming address in the accept cycle.
  assign rd_en  = (accept && (WAIT == 0)) || ((state == ST_WAIT) && (wait_cnt == 4'd1));
  assign rd_idx = (state == ST_IDLE) ? req_idx : addr_idx;
  assign wr_en  = ld_en && ld_ok;

  imem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk    (clk),
    .rd_en  (rd_en),
    .rd_idx (rd_idx),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_idx (ld_idx),
    .wr_data(ld_data)
  );

  // The RAM output register has no reset, so the data output is gated by
  // resp_valid to read as zero outside a response.
  assign resp_data = resp_valid ? (resp_err ? ERR_WORD : rd_data) : 32'd0;

  // Request FSM. req_ready only rises on the edge that completes a response,
  // so a new request can never be taken in the completion cycle itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      wait_cnt   <= 4'd0;
      addr_idx   <= '0;
      addr_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_idx  <= req_idx;
            addr_err  <= !req_ok;
            req_ready <= 1'b0;
            if (WAIT == 0) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= !req_ok;
              wait_cnt   <= 4'd0;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(WAIT);
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= addr_err;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
